// File: rtl/wb_ram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ram_slave_if
//  Brief    : Wishbone B4 pipelined bus bundle between a master and the RAM slave.
//  Revision : 1.0
// ============================================================================
interface wb_ram_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_stall_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ram_slave
//  Brief    : Wishbone B4 pipelined RAM slave with fixed-latency in-order acks.
//             Define WB_RAM_SLAVE_STALL_INJECT_EN to add LFSR stall injection.
//  Revision : 1.0
// ============================================================================
module wb_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    wb_ram_slave_if.slave  bus
);
    localparam int c_AW = $clog2(DEPTH_WORDS);

    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [c_AW-1:0]    w_idx;
    logic               w_in_range;
    logic               w_accept;
    logic               w_stall;
    logic [31:0]        w_rdata;
    logic               w_unused_adr_lsb;

    assign w_idx            = bus.wb_adr_i[c_AW+1:2];
    assign w_in_range       = (bus.wb_adr_i[31:c_AW+2] == '0);
    assign w_accept         = rst_ni & bus.wb_cyc_i & bus.wb_stb_i & ~w_stall;
    assign w_rdata          = w_in_range ? r_mem[w_idx] : 32'h0;
    assign w_unused_adr_lsb = &{1'b0, bus.wb_adr_i[1:0]};

    // Asynchronous read lets a read accepted right after a write see the new word.
    always_ff @(posedge clk_i) begin
        if (w_accept && bus.wb_we_i && w_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.wb_sel_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= bus.wb_dat_i[8*k +: 8];
                end
            end
        end
    end

`ifdef WB_RAM_SLAVE_STALL_INJECT_EN
    localparam logic [7:0] c_LFSR_SEED = 8'hA5;

    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_stall   = (r_lfsr[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= c_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_we;
    logic [31:0]        r_dat [LATENCY];
    logic [LATENCY-1:0] w_vld_nxt;
    logic [LATENCY-1:0] w_we_nxt;
    logic [31:0]        w_dat_nxt [LATENCY];

    // Dropping wb_cyc_i kills every in-flight entry; data only moves with a valid
    // entry so wb_dat_o holds its last value between acks.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_vld_nxt[gi] = w_accept;
            assign w_we_nxt[gi]  = bus.wb_we_i;
            assign w_dat_nxt[gi] = w_rdata;
        end else begin : g_tail
            assign w_vld_nxt[gi] = r_vld[gi-1] & bus.wb_cyc_i;
            assign w_we_nxt[gi]  = r_we[gi-1];
            assign w_dat_nxt[gi] = r_dat[gi-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            r_we  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= 32'h0;
            end
        end else begin
            r_vld <= w_vld_nxt;
            for (int i = 0; i < LATENCY; i++) begin
                if (w_vld_nxt[i]) begin
                    r_we[i]  <= w_we_nxt[i];
                    r_dat[i] <= w_dat_nxt[i];
                end
            end
        end
    end

    assign bus.wb_ack_o   = r_vld[LATENCY-1];
    assign bus.wb_dat_o   = r_we[LATENCY-1] ? 32'h0 : r_dat[LATENCY-1];
    assign bus.wb_stall_o = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_ram_slave
//  Brief    : Self-checking bench for wb_ram_slave: vector table, scoreboard of
//             expected acks, abort, mid-transfer reset and random stalled traffic.
//  Revision : 1.0
// ============================================================================
module tb_wb_ram_slave;
    localparam int c_LAT   = 3;
    localparam int c_DEPTH = 1024;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cnt = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_acks = 0;
    logic [31:0] last_dat = 32'h0;
    sb_t  sb[$];
    sb_t  e;
    vec_t tbl[15];
    logic [31:0] model [16];

    wb_ram_slave_if bus();

    wb_ram_slave #(.DEPTH_WORDS(c_DEPTH), .LATENCY(c_LAT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cnt);
        end
    endtask

    // Ack monitor: every ack must match the oldest expectation at its exact cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            last_dat = 32'h0;
        end else begin
            if (bus.wb_ack_o === 1'b1) begin
                n_acks++;
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_cycle", cnt, e.due);
                    check("ack_data", bus.wb_dat_o, e.exp);
                end
                last_dat = bus.wb_dat_o;
            end else begin
                check("dat_hold", bus.wb_dat_o, last_dat);
                if (sb.size() != 0 && sb[0].due < cnt) begin
                    e = sb.pop_front();
                    check("missed_ack", cnt, e.due);
                end
            end
            if (bus.wb_cyc_i !== 1'b1) sb.delete();
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp);
        int  waits;
        bit  done;
        sb_t item;
        waits = 0;
        done  = 0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        while (!done) begin
            @(negedge clk);
            if (bus.wb_stall_o !== 1'b1) begin
                item.due = cnt + c_LAT;
                item.exp = exp;
                sb.push_back(item);
                done = 1;
            end else if (++waits > 64) begin
                check("stall_timeout", 32'd1, 32'd0);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.wb_stb_i = 1'b0;
        while (sb.size() != 0 && t < c_LAT + 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int j;
        logic [31:0] d;
        logic [3:0]  s;
        bit          w;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0};
        tbl[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0};
        tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h11BB_33DD};
        tbl[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0};
        tbl[6]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0};
        tbl[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 32'h0};
        tbl[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hCAFE_F00D};
        tbl[9]  = '{1'b1, 32'h0000_0004, 32'h0,         4'hF, 32'h0};
        tbl[10] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'h8, 32'h0};
        tbl[11] = '{1'b0, 32'h0000_0004, 32'h0,         4'hF, 32'hFF00_0000};
        tbl[12] = '{1'b0, 32'h0000_0013, 32'h0,         4'hF, 32'hDEAD_BEEF};
        tbl[13] = '{1'b1, 32'h8000_0010, 32'h0BAD_F00D, 4'hF, 32'h0};
        tbl[14] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};

        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("reset_dat", bus.wb_dat_o, 32'h0);
        check("reset_stall", {31'h0, bus.wb_stall_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table, issued back to back
        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].exp);
        end
        drain();

        // Eight consecutive reads with no bubbles
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 32'(i * 4), 32'h0, 4'hF, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
        end
        drain();

        // Cycle abort: two reads in flight, then wb_cyc_i drops with a strobe held
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h11BB_33DD);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b1;
        @(negedge clk);
        #1;
        base = n_acks;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_no_ack", n_acks - base, 32'd0);
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset with requests in flight; the accepted write survives
        issue(1'b1, 32'h0000_0040, 32'h55AA_55AA, 4'hF, 32'h0);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("midrst_dat", bus.wb_dat_o, 32'h0);
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h55AA_55AA);
        drain();

        // Random traffic held until accepted, checked against a reference model
        base = n_acks;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            issue(1'b1, 32'h100 + 32'(i * 4), model[i], 4'hF, 32'h0);
        end
        for (int i = 0; i < 64; i++) begin
            w = 1'($urandom_range(0, 1));
            j = $urandom_range(0, 15);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (w) begin
                issue(1'b1, 32'h100 + 32'(j * 4), d, s, 32'h0);
                for (int k = 0; k < 4; k++) begin
                    if (s[k]) model[j][8*k +: 8] = d[8*k +: 8];
                end
            end else begin
                issue(1'b0, 32'h100 + 32'(j * 4), 32'h0, 4'hF, model[j]);
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
        drain();
        check("random_ack_count", n_acks - base, 32'd80);
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, model[i]);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
